// File: rtl/cache_port_arbiter.sv
// Arbitrates one cache controller between the instruction port, the data port
// and flush requests, sequencing ctrl through issue, wait and park phases.
module cache_port_arbiter #(
  parameter int ramWidth = 8,
  parameter int addrSize = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifReq,
  input  logic [addrSize-1:0] ifAddr,
  output logic                ifAck,
  output logic [ramWidth-1:0] ifData,
  input  logic                dReq,
  input  logic                dWrite,
  input  logic                dIndirect,
  input  logic [addrSize-1:0] dAddr,
  input  logic [ramWidth-1:0] dWData,
  output logic                dAck,
  output logic [ramWidth-1:0] dRData,
  input  logic                flushReq,
  output logic                flushAck,
  output logic [1:0]          ccCtrl,
  output logic [addrSize-1:0] ccAddr,
  output logic [ramWidth-1:0] ccDataIn,
  output logic                ccIndirect,
  input  logic                ccOutputReady,
  input  logic [ramWidth-1:0] ccDataOut,
  output logic                grantId,
  output logic                busy,
  output logic                timeoutErr
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 2);

  localparam logic [1:0] CTRL_CLEAR = 2'b00;
  localparam logic [1:0] CTRL_IDLE  = 2'b01;
  localparam logic [1:0] CTRL_READ  = 2'b10;
  localparam logic [1:0] CTRL_WRITE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    FLUSH,
    FLUSH_HOLD
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] wait_cnt;
  logic          hold_cnt;
  logic          last_grant;
  logic          ack_pending;
  logic          if_want, d_want, flush_want;
  logic          grant_data, grant_any, timeout_hit;

  // A port whose ack is high this cycle may still hold req; that is not a new request.
  always_comb begin
    if_want     = ifReq && !ifAck;
    d_want      = dReq && !dAck;
    flush_want  = flushReq && !flushAck;
    grant_data  = d_want && (!if_want || !last_grant);
    grant_any   = if_want || d_want;
    timeout_hit = !ccOutputReady && (wait_cnt == LAST_WAIT);
    state_next  = state;
    case (state)
      IDLE: begin
        if (flush_want) begin
          state_next = FLUSH;
        end else if (grant_any) begin
          state_next = ISSUE;
        end
      end
      ISSUE:      state_next = WAIT;
      WAIT:       if (ccOutputReady || timeout_hit) state_next = DONE;
      DONE:       state_next = IDLE;
      FLUSH:      state_next = FLUSH_HOLD;
      FLUSH_HOLD: if (hold_cnt) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccCtrl      <= CTRL_IDLE;
      ccAddr      <= '0;
      ccDataIn    <= '0;
      ccIndirect  <= 1'b0;
      ifData      <= '0;
      dRData      <= '0;
      ifAck       <= 1'b0;
      dAck        <= 1'b0;
      flushAck    <= 1'b0;
      grantId     <= 1'b0;
      busy        <= 1'b0;
      timeoutErr  <= 1'b0;
      last_grant  <= 1'b1;
      ack_pending <= 1'b0;
      wait_cnt    <= '0;
      hold_cnt    <= 1'b0;
    end else begin
      ifAck    <= 1'b0;
      dAck     <= 1'b0;
      flushAck <= 1'b0;
      busy     <= (state_next != IDLE);
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (flush_want) begin
            ccCtrl <= CTRL_CLEAR;
          end else if (grant_any) begin
            grantId    <= grant_data;
            last_grant <= grant_data;
            if (grant_data) begin
              ccCtrl     <= dWrite ? CTRL_WRITE : CTRL_READ;
              ccAddr     <= dAddr;
              ccDataIn   <= dWData;
              ccIndirect <= dIndirect;
            end else begin
              ccCtrl     <= CTRL_READ;
              ccAddr     <= ifAddr;
              ccDataIn   <= '0;
              ccIndirect <= 1'b0;
            end
          end
        end
        // Completion wins over a timeout landing on the same cycle.
        WAIT: begin
          if (ccOutputReady) begin
            if (ccCtrl == CTRL_READ) begin
              if (grantId) begin
                dRData <= ccDataOut;
              end else begin
                ifData <= ccDataOut;
              end
            end
            ack_pending <= 1'b1;
            ccCtrl      <= CTRL_IDLE;
            wait_cnt    <= '0;
          end else if (timeout_hit) begin
            timeoutErr <= 1'b1;
            if (grantId) begin
              dAck <= 1'b1;
            end else begin
              ifAck <= 1'b1;
            end
            ccCtrl   <= CTRL_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          if (ack_pending) begin
            if (grantId) begin
              dAck <= 1'b1;
            end else begin
              ifAck <= 1'b1;
            end
          end
          ack_pending <= 1'b0;
        end
        FLUSH: begin
          ccCtrl   <= CTRL_IDLE;
          hold_cnt <= 1'b0;
        end
        FLUSH_HOLD: begin
          hold_cnt <= 1'b1;
          if (hold_cnt) flushAck <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a transaction-level model.
module tb_cache_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ifReq = 1'b0;
  logic [AW-1:0] ifAddr = '0;
  logic          ifAck;
  logic [DW-1:0] ifData;
  logic          dReq = 1'b0;
  logic          dWrite = 1'b0;
  logic          dIndirect = 1'b0;
  logic [AW-1:0] dAddr = '0;
  logic [DW-1:0] dWData = '0;
  logic          dAck;
  logic [DW-1:0] dRData;
  logic          flushReq = 1'b0;
  logic          flushAck;
  logic [1:0]    ccCtrl;
  logic [AW-1:0] ccAddr;
  logic [DW-1:0] ccDataIn;
  logic          ccIndirect;
  logic          ccOutputReady = 1'b0;
  logic [DW-1:0] ccDataOut = '0;
  logic          grantId;
  logic          busy;
  logic          timeoutErr;

  cache_port_arbiter #(.ramWidth(DW), .addrSize(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifAck(ifAck), .ifData(ifData),
    .dReq(dReq), .dWrite(dWrite), .dIndirect(dIndirect), .dAddr(dAddr),
    .dWData(dWData), .dAck(dAck), .dRData(dRData),
    .flushReq(flushReq), .flushAck(flushAck),
    .ccCtrl(ccCtrl), .ccAddr(ccAddr), .ccDataIn(ccDataIn), .ccIndirect(ccIndirect),
    .ccOutputReady(ccOutputReady), .ccDataOut(ccDataOut),
    .grantId(grantId), .busy(busy), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit random_fields = 1'b0;
  bit spurious_en = 1'b0;
  bit force_data = 1'b0;
  logic [DW-1:0] force_val = '0;
  int next_delay = 1;

  // Model: mode 0 idle, 1 access, 2 flush; age counts edges since the grant.
  int mdl_mode, mdl_age, mdl_delay;
  bit mdl_finished, mdl_normal, mdl_owner, mdl_read, mdl_last;
  logic [1:0]    exp_ctrl;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data_in, exp_if_data, exp_d_data;
  bit exp_ind, exp_if_ack, exp_d_ack, exp_f_ack, exp_gid, exp_busy, exp_terr;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  task automatic mdlReset();
    mdl_mode = 0; mdl_age = 0; mdl_delay = 0;
    mdl_finished = 0; mdl_normal = 0; mdl_owner = 0; mdl_read = 0; mdl_last = 1;
    exp_ctrl = 2'b01; exp_addr = '0; exp_data_in = '0; exp_if_data = '0; exp_d_data = '0;
    exp_ind = 0; exp_if_ack = 0; exp_d_ack = 0; exp_f_ack = 0;
    exp_gid = 0; exp_busy = 0; exp_terr = 0;
  endtask

  task automatic mdlAck();
    if (mdl_owner) exp_d_ack = 1; else exp_if_ack = 1;
  endtask

  task automatic mdlStep();
    bit want_if, want_d;
    want_if = ifReq && !exp_if_ack;
    want_d  = dReq && !exp_d_ack;
    if (mdl_mode == 0) begin
      if (flushReq && !exp_f_ack) begin
        exp_if_ack = 0; exp_d_ack = 0; exp_f_ack = 0;
        exp_ctrl = 2'b00; mdl_mode = 2; mdl_age = 0; exp_busy = 1;
      end else if (want_if || want_d) begin
        exp_if_ack = 0; exp_d_ack = 0; exp_f_ack = 0;
        mdl_owner = want_d && (!want_if || !mdl_last);
        mdl_last = mdl_owner;
        exp_gid = mdl_owner;
        if (mdl_owner) begin
          mdl_read = !dWrite; exp_ctrl = dWrite ? 2'b11 : 2'b10;
          exp_addr = dAddr; exp_data_in = dWData; exp_ind = dIndirect;
        end else begin
          mdl_read = 1; exp_ctrl = 2'b10; exp_addr = ifAddr; exp_ind = 0;
        end
        mdl_mode = 1; mdl_age = 0; mdl_finished = 0; mdl_delay = next_delay; exp_busy = 1;
      end else begin
        exp_if_ack = 0; exp_d_ack = 0; exp_f_ack = 0;
      end
    end else if (mdl_mode == 1) begin
      exp_if_ack = 0; exp_d_ack = 0; exp_f_ack = 0;
      if (mdl_finished) begin
        if (mdl_normal) mdlAck();
        mdl_mode = 0; exp_busy = 0;
      end else begin
        if (mdl_age >= 1) begin
          if (ccOutputReady) begin
            if (mdl_read) begin
              if (mdl_owner) exp_d_data = ccDataOut; else exp_if_data = ccDataOut;
            end
            exp_ctrl = 2'b01; mdl_finished = 1; mdl_normal = 1;
          end else if (mdl_age == TO - 1) begin
            exp_terr = 1; mdlAck();
            exp_ctrl = 2'b01; mdl_finished = 1; mdl_normal = 0;
          end
        end
        mdl_age++;
      end
    end else begin
      exp_if_ack = 0; exp_d_ack = 0; exp_f_ack = 0;
      if (mdl_age == 0) exp_ctrl = 2'b01;
      if (mdl_age == 2) begin
        exp_f_ack = 1; mdl_mode = 0; exp_busy = 0;
      end
      mdl_age++;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdlReset();
    else mdlStep();
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      checkOutput("ccCtrl", ccCtrl, exp_ctrl);
      checkOutput("ccAddr", ccAddr, exp_addr);
      checkOutput("ccIndirect", ccIndirect, exp_ind);
      if (exp_ctrl == 2'b11) checkOutput("ccDataIn", ccDataIn, exp_data_in);
      checkOutput("ifData", ifData, exp_if_data);
      checkOutput("dRData", dRData, exp_d_data);
      checkOutput("ifAck", ifAck, exp_if_ack);
      checkOutput("dAck", dAck, exp_d_ack);
      checkOutput("flushAck", flushAck, exp_f_ack);
      checkOutput("grantId", grantId, exp_gid);
      checkOutput("busy", busy, exp_busy);
      checkOutput("timeoutErr", timeoutErr, exp_terr);
    end
  end

  // Advance one cycle and drive the controller side (and random traffic when enabled).
  task automatic applyStimulus();
    bit in_wait;
    int r;
    @(posedge clk);
    #1;
    in_wait = (mdl_mode == 1) && !mdl_finished && (mdl_age >= 1);
    ccOutputReady = (in_wait && mdl_delay != 0 && mdl_age == mdl_delay) ||
                    (!in_wait && spurious_en && $urandom_range(0, 4) == 0);
    ccDataOut = force_data ? force_val : DW'($urandom);
    if (random_fields) begin
      ifAddr = AW'($urandom); dAddr = AW'($urandom); dWData = DW'($urandom);
      dWrite = 1'($urandom); dIndirect = 1'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0) next_delay = 0;
      else if (r <= 6) next_delay = $urandom_range(1, 4);
      else if (r <= 8) next_delay = $urandom_range(5, TO - 1);
      else next_delay = TO - 1;
      if (ifReq) begin
        if (exp_if_ack ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 49) == 0)) ifReq = 0;
      end else if ($urandom_range(0, 3) == 0) ifReq = 1;
      if (dReq) begin
        if (exp_d_ack ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 49) == 0)) dReq = 0;
      end else if ($urandom_range(0, 3) == 0) dReq = 1;
      if (flushReq) begin
        if (exp_f_ack) flushReq = 0;
      end else if ($urandom_range(0, 39) == 0) flushReq = 1;
    end
  endtask

  task automatic waitAck(input int which, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      applyStimulus();
      seen = (which == 0) ? ifAck : (which == 1) ? dAck : flushAck;
    end
    if (!seen) checkOutput(name, 0, 1);
  endtask

  initial begin
    int n_ctrl, n_ack, k;
    bit seen;
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    cmp_en = 1;
    checkOutput("reset_ccCtrl", ccCtrl, 2'b01);
    checkOutput("reset_busy", busy, 0);

    // Simultaneous requests: instruction first after reset, then data write.
    ifReq = 1; ifAddr = 8'h21; dReq = 1; dWrite = 1; dAddr = 8'h40; dWData = 8'h3C; next_delay = 2;
    applyStimulus();
    checkOutput("pair_first_ctrl", ccCtrl, 2'b10);
    checkOutput("pair_first_gid", grantId, 0);
    waitAck(0, "pair_if_ack_bound");
    ifReq = 0;
    applyStimulus();
    checkOutput("pair_second_ctrl", ccCtrl, 2'b11);
    checkOutput("pair_second_data", ccDataIn, 8'h3C);
    checkOutput("pair_second_addr", ccAddr, 8'h40);
    checkOutput("pair_second_gid", grantId, 1);
    waitAck(1, "pair_d_ack_bound");
    dReq = 0;

    // Flush beats both ports, then instruction wins since data was served last.
    flushReq = 1; ifReq = 1; ifAddr = 8'h33; dReq = 1; dWrite = 0; dAddr = 8'h55; next_delay = 1;
    applyStimulus();
    checkOutput("flush_clear", ccCtrl, 2'b00);
    applyStimulus();
    checkOutput("flush_one_cycle", ccCtrl, 2'b01);
    applyStimulus();
    checkOutput("flush_ack_early", flushAck, 0);
    applyStimulus();
    checkOutput("flush_ack", flushAck, 1);
    flushReq = 0;
    applyStimulus();
    checkOutput("after_flush_ctrl", ccCtrl, 2'b10);
    checkOutput("after_flush_gid", grantId, 0);
    waitAck(0, "after_flush_if_bound");
    ifReq = 0;
    waitAck(1, "after_flush_d_bound");
    dReq = 0;

    // Indirect data read, controller answers in the 10th wait cycle.
    dReq = 1; dWrite = 0; dIndirect = 1; dAddr = 8'h08; next_delay = 10;
    n_ctrl = 0; n_ack = 0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus();
      if (ccCtrl == 2'b10 && ccIndirect && ccAddr == 8'h08) n_ctrl++;
      if (dAck) begin n_ack++; dReq = 0; end
    end
    dIndirect = 0;
    checkOutput("indirect_hold_cycles", n_ctrl, 11);
    checkOutput("indirect_ack_count", n_ack, 1);

    // Plain instruction read with fixed return data.
    ifReq = 1; ifAddr = 8'h12; next_delay = 1; force_data = 1; force_val = 8'hA5;
    applyStimulus();
    checkOutput("t1_ctrl", ccCtrl, 2'b10);
    checkOutput("t1_addr", ccAddr, 8'h12);
    applyStimulus();
    applyStimulus();
    checkOutput("t1_done_ctrl", ccCtrl, 2'b01);
    checkOutput("t1_done_noack", ifAck, 0);
    applyStimulus();
    checkOutput("t1_ack", ifAck, 1);
    checkOutput("t1_data", ifData, 8'hA5);
    ifReq = 0; force_data = 0;
    applyStimulus();
    checkOutput("t1_ack_one_cycle", ifAck, 0);

    // Controller never answers: abort after TO-1 wait cycles.
    ifReq = 1; ifAddr = 8'h77; next_delay = 0;
    applyStimulus();
    k = 0; seen = 0;
    while (!seen && k < 3 * TO) begin
      applyStimulus();
      k++;
      seen = ifAck;
    end
    checkOutput("timeout_latency", k, TO);
    checkOutput("timeout_flag", timeoutErr, 1);
    checkOutput("timeout_data_kept", ifData, 8'hA5);
    ifReq = 0;
    applyStimulus();
    checkOutput("timeout_ack_one_cycle", ifAck, 0);
    dReq = 1; dWrite = 1; dAddr = 8'h09; dWData = 8'h5A; next_delay = 3;
    waitAck(1, "post_timeout_bound");
    dReq = 0;
    checkOutput("timeout_sticky", timeoutErr, 1);

    // Reset in the middle of a wait abandons the transaction.
    ifReq = 1; ifAddr = 8'h44; next_delay = 0;
    repeat (4) applyStimulus();
    #2 rst_n = 0;
    #1;
    checkOutput("rst_ctrl", ccCtrl, 2'b01);
    checkOutput("rst_addr", ccAddr, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_terr", timeoutErr, 0);
    checkOutput("rst_ifdata", ifData, 0);
    checkOutput("rst_gid", grantId, 0);
    ifReq = 0;
    repeat (2) begin
      applyStimulus();
      checkOutput("rst_no_ack", ifAck, 0);
    end
    @(posedge clk);
    #3 rst_n = 1;

    // Random traffic against the model.
    random_fields = 1; spurious_en = 1;
    repeat (4000) applyStimulus();
    random_fields = 0; spurious_en = 0;
    ifReq = 0; dReq = 0; flushReq = 0;
    repeat (3 * TO) applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares the single cache controller between the instruction-fetch port and the data port, plus a cache-flush request.
- Sits between the fetch/execute units and the cache controller's ctrl/addr/dataIn/indirect/outputReady interface.
- Sequences each transaction so that ctrl is presented correctly at the controller's start, indirect-check and indirect-address sampling points.
- Returns ctrl to idle after completion so the controller never re-issues a transaction.

Parameters:
- ramWidth, 8, data word width.
- addrSize, 8, address width.
- TIMEOUT, 64, maximum WAIT cycles before a transaction is aborted; must be at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ifReq  in  1  instruction read request; held until ifAck.
- ifAddr  in  addrSize  instruction address.
- ifAck  out  1  one-cycle completion pulse.
- ifData  out  ramWidth  instruction word, valid from ifAck onward.
- dReq  in  1  data request; held until dAck.
- dWrite  in  1  1=write, 0=read.
- dIndirect  in  1  indirect-addressing request.
- dAddr  in  addrSize  data address.
- dWData  in  ramWidth  write data.
- dAck  out  1  one-cycle completion pulse.
- dRData  out  ramWidth  read data, valid from dAck onward.
- flushReq  in  1  cache clear request.
- flushAck  out  1  one-cycle flush-done pulse.
- ccCtrl  out  2  to controller: 00 clear, 01 idle, 10 read, 11 write.
- ccAddr  out  addrSize  to controller addr.
- ccDataIn  out  ramWidth  to controller dataIn.
- ccIndirect  out  1  to controller indirect.
- ccOutputReady  in  1  controller completion strobe.
- ccDataOut  in  ramWidth  cache read data.
- grantId  out  1  0=instruction, 1=data; owner of the current or most recent grant.
- busy  out  1  high in every state except IDLE.
- timeoutErr  out  1  sticky abort flag.

Behaviour:
- All outputs are registered.
- Reset (async, rst_n=0):
  - ccCtrl=01; ccAddr, ccDataIn, ccIndirect, ifData, dRData = 0.
  - All acks = 0; grantId=0; busy=0; timeoutErr=0.
  - lastGrant=data, so the instruction port wins the first tie.
  - state=IDLE; wait counter = 0.
  - Reset mid-transaction abandons it with no ack.
- States: IDLE, ISSUE, WAIT, DONE, FLUSH, FLUSH_HOLD.
- IDLE:
  - Priority: flushReq > round-robin(ifReq, dReq).
  - If both ports request, grant the port not in lastGrant; otherwise grant the sole requester.
  - On grant, load ccAddr/ccDataIn/ccIndirect and ccCtrl (10 or 11), set grantId, update lastGrant, go to ISSUE.
  - Instruction grant: ccCtrl=10, ccIndirect=0.
  - On flushReq: ccCtrl=00, go to FLUSH.
- ISSUE: hold all cc outputs for one cycle, then go to WAIT.
- WAIT:
  - ccCtrl/ccAddr/ccDataIn/ccIndirect stay constant throughout, because the controller resamples ctrl after indirect resolution.
  - The wait counter increments every WAIT cycle.
  - On ccOutputReady=1:
    - If the transaction is a read, capture ccDataOut into ifData or dRData.
    - Pulse the owner's ack next cycle; set ccCtrl=01; clear the counter; go to DONE.
  - Timeout: counter reaches TIMEOUT-1 with no ccOutputReady.
    - Set timeoutErr (sticky until reset); pulse the owner's ack; the data output is unchanged.
    - Set ccCtrl=01; go to DONE.
  - ccOutputReady and timeout in the same cycle: treat as normal completion; timeoutErr is not set.
- DONE: one cycle with ccCtrl=01 so the controller parks in start, then go to IDLE. A new grant is possible no earlier than the cycle after DONE.
- FLUSH: ccCtrl=00 for exactly one cycle, then ccCtrl=01 and go to FLUSH_HOLD.
- FLUSH_HOLD: remain 2 cycles (controller clrState→start), pulse flushAck, go to IDLE.
- Requester rules:
  - Address and data are captured at grant; they need not be stable afterwards.
  - If req drops before ack, the transaction still completes and ack still pulses.
  - If req is still high the cycle after ack, it is a new request.
- Requests arriving while busy wait; none are lost while req is held.
- ccOutputReady seen in IDLE, DONE, FLUSH or FLUSH_HOLD is ignored.
- Ack pulses are exactly one cycle; at most one ack is high per cycle.
- Latency:
  - Grant registered at edge N; ccCtrl valid from N.
  - Ack is the edge after the edge that samples ccOutputReady.
  - Minimum request-to-ack is 4 cycles plus controller latency.

Test Plan:
- Reset, then ifReq=1 with ifAddr=0x12, controller returns ccDataOut=0xA5 → ccCtrl=10, ccAddr=0x12; one-cycle ifAck; ifData=0xA5; ccCtrl=01 in DONE.
- ifReq and dReq (dWrite=1, dAddr=0x40, dWData=0x3C) raised together and held → instruction served first, then data (ccCtrl=11, ccDataIn=0x3C); a second simultaneous pair serves data first only if lastGrant=instruction.
- flushReq asserted together with ifReq and dReq → flush first: ccCtrl=00 for exactly 1 cycle, flushAck 3 cycles later, then instruction granted.
- Data indirect read (dIndirect=1, dAddr=0x08) with ccOutputReady delayed 10 cycles → ccCtrl=10 and ccIndirect=1 held for all 10 WAIT cycles; dAck once.
- ccOutputReady never asserted with TIMEOUT=8 → ack on the cycle after the 7th WAIT cycle; timeoutErr=1 and sticky; next request still serviced normally.
- rst_n pulled low during WAIT → all outputs return to reset values asynchronously; no ack; ccCtrl=01.
